// File: rtl/pit_bus_master.sv
// pit_bus_master: turns raw-write / program-channel / read-channel commands
// into timed 8253 bus cycles (setup, strobe, hold, recovery per byte).
module pit_bus_master #(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1,
    parameter int RECOV_CYC  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [1:0]  cmd_addr,
    input  logic [1:0]  cmd_chan,
    input  logic [2:0]  cmd_mode,
    input  logic [15:0] cmd_data,
    output logic        done,
    output logic        err,
    output logic [15:0] rsp_data,
    output logic        cs_n,
    output logic        rd_n,
    output logic        wr_n,
    output logic        a1,
    output logic        a0,
    output logic [7:0]  d_out,
    output logic        d_oe,
    input  logic [7:0]  d_in
);

    localparam logic [1:0] OP_RAW  = 2'b00;
    localparam logic [1:0] OP_PROG = 2'b01;
    localparam logic [1:0] OP_READ = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_RECOV
    } state_t;

    // Describes byte number idx of a command as {is_read, addr[1:0], wdata[7:0]}.
    function automatic logic [10:0] byte_info(
        input logic [1:0]  op,
        input logic [1:0]  addr,
        input logic [1:0]  chan,
        input logic [2:0]  mode,
        input logic [15:0] data,
        input logic [1:0]  idx
    );
        logic [10:0] r;
        r = '0;
        case (op)
            OP_RAW:  r = {1'b0, addr, data[7:0]};
            OP_PROG: begin
                case (idx)
                    2'd0:    r = {1'b0, 2'b11, chan, 2'b11, mode, 1'b0};
                    2'd1:    r = {1'b0, chan, data[7:0]};
                    default: r = {1'b0, chan, data[15:8]};
                endcase
            end
            OP_READ: begin
                if (idx == 2'd0) r = {1'b0, 2'b11, chan, 6'b000000};
                else             r = {1'b1, chan, 8'h00};
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic [1:0]  op_q, op_d;
    logic [1:0]  addr_q, addr_d;
    logic [1:0]  chan_q, chan_d;
    logic [2:0]  mode_q, mode_d;
    logic [15:0] data_q, data_d;
    logic [7:0]  lsb_q, lsb_d;
    logic [7:0]  msb_q, msb_d;

    logic        cmd_ready_q, cmd_ready_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [15:0] rsp_data_q, rsp_data_d;
    logic        cs_n_q, cs_n_d;
    logic        rd_n_q, rd_n_d;
    logic        wr_n_q, wr_n_d;
    logic        a1_q, a1_d;
    logic        a0_q, a0_d;
    logic [7:0]  d_out_q, d_out_d;
    logic        d_oe_q, d_oe_d;

    logic [10:0] cur_info;
    logic [10:0] ld_info;
    logic        cur_rd;
    logic        is_last;
    logic        bad_cmd;

    // Next-state, counter, command capture and next output values
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        op_d        = op_q;
        addr_d      = addr_q;
        chan_d      = chan_q;
        mode_d      = mode_q;
        data_d      = data_q;
        lsb_d       = lsb_q;
        msb_d       = msb_q;
        cmd_ready_d = cmd_ready_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        rsp_data_d  = rsp_data_q;
        cs_n_d      = cs_n_q;
        rd_n_d      = rd_n_q;
        wr_n_d      = wr_n_q;
        a1_d        = a1_q;
        a0_d        = a0_q;
        d_out_d     = d_out_q;
        d_oe_d      = d_oe_q;

        cur_info = byte_info(op_q, addr_q, chan_q, mode_q, data_q, idx_q);
        cur_rd   = cur_info[10];
        is_last  = (op_q == OP_RAW) || (idx_q == 2'd2);
        bad_cmd  = (cmd_op == 2'b11) || ((cmd_op != OP_RAW) && (cmd_chan == 2'b11));

        // The first byte comes straight from the command inputs; later bytes
        // come from the captured copy.
        if (state_q == S_IDLE)
            ld_info = byte_info(cmd_op, cmd_addr, cmd_chan, cmd_mode, cmd_data, 2'd0);
        else
            ld_info = byte_info(op_q, addr_q, chan_q, mode_q, data_q, idx_q + 2'd1);

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    op_d   = cmd_op;
                    addr_d = cmd_addr;
                    chan_d = cmd_chan;
                    mode_d = cmd_mode;
                    data_d = cmd_data;
                    if (bad_cmd) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        state_d     = S_SETUP;
                        cnt_d       = 8'(SETUP_CYC - 1);
                        idx_d       = 2'd0;
                        cmd_ready_d = 1'b0;
                        cs_n_d      = 1'b0;
                        a1_d        = ld_info[9];
                        a0_d        = ld_info[8];
                        d_out_d     = ld_info[7:0];
                        d_oe_d      = ~ld_info[10];
                    end
                end
            end

            S_SETUP: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_STROBE;
                    cnt_d   = 8'(STROBE_CYC - 1);
                    if (cur_rd) rd_n_d = 1'b0;
                    else        wr_n_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            S_STROBE: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_HOLD;
                    cnt_d   = 8'(HOLD_CYC - 1);
                    rd_n_d  = 1'b1;
                    wr_n_d  = 1'b1;
                    // d_in is taken on the edge that ends the strobe
                    if (cur_rd) begin
                        if (idx_q == 2'd1) lsb_d = d_in;
                        else               msb_d = d_in;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            S_HOLD: begin
                if (cnt_q == 8'd0) begin
                    cs_n_d = 1'b1;
                    d_oe_d = 1'b0;
                    // The final recovery cycle of the last byte doubles as the
                    // idle/done cycle, so with one recovery cycle finish now.
                    if (is_last && (RECOV_CYC == 1)) begin
                        state_d     = S_IDLE;
                        cmd_ready_d = 1'b1;
                        done_d      = 1'b1;
                        if (op_q == OP_READ) rsp_data_d = {msb_q, lsb_q};
                    end else begin
                        state_d = S_RECOV;
                        cnt_d   = 8'(RECOV_CYC - 1);
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            S_RECOV: begin
                if (is_last) begin
                    if (cnt_q <= 8'd1) begin
                        state_d     = S_IDLE;
                        cmd_ready_d = 1'b1;
                        done_d      = 1'b1;
                        if (op_q == OP_READ) rsp_data_d = {msb_q, lsb_q};
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end else if (cnt_q == 8'd0) begin
                    state_d = S_SETUP;
                    cnt_d   = 8'(SETUP_CYC - 1);
                    idx_d   = idx_q + 2'd1;
                    cs_n_d  = 1'b0;
                    a1_d    = ld_info[9];
                    a0_d    = ld_info[8];
                    d_out_d = ld_info[7:0];
                    d_oe_d  = ~ld_info[10];
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            default: begin
                state_d     = S_IDLE;
                cmd_ready_d = 1'b1;
                cs_n_d      = 1'b1;
                rd_n_d      = 1'b1;
                wr_n_d      = 1'b1;
                d_oe_d      = 1'b0;
            end
        endcase
    end

    // State register, captured command and all registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            op_q        <= '0;
            addr_q      <= '0;
            chan_q      <= '0;
            mode_q      <= '0;
            data_q      <= '0;
            lsb_q       <= '0;
            msb_q       <= '0;
            cmd_ready_q <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rsp_data_q  <= '0;
            cs_n_q      <= 1'b1;
            rd_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
            a1_q        <= 1'b0;
            a0_q        <= 1'b0;
            d_out_q     <= '0;
            d_oe_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            chan_q      <= chan_d;
            mode_q      <= mode_d;
            data_q      <= data_d;
            lsb_q       <= lsb_d;
            msb_q       <= msb_d;
            cmd_ready_q <= cmd_ready_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rsp_data_q  <= rsp_data_d;
            cs_n_q      <= cs_n_d;
            rd_n_q      <= rd_n_d;
            wr_n_q      <= wr_n_d;
            a1_q        <= a1_d;
            a0_q        <= a0_d;
            d_out_q     <= d_out_d;
            d_oe_q      <= d_oe_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign done      = done_q;
    assign err       = err_q;
    assign rsp_data  = rsp_data_q;
    assign cs_n      = cs_n_q;
    assign rd_n      = rd_n_q;
    assign wr_n      = wr_n_q;
    assign a1        = a1_q;
    assign a0        = a0_q;
    assign d_out     = d_out_q;
    assign d_oe      = d_oe_q;

endmodule

// File: tb/tb_pit_bus_master.sv
// Randomized bench for pit_bus_master: a bus monitor reconstructs every 8253
// bus cycle and a command-level model predicts bytes, timing and responses.
`timescale 1ns/1ps
module tb_pit_bus_master;

    localparam int SETUP_CYC  = 1;
    localparam int STROBE_CYC = 2;
    localparam int HOLD_CYC   = 1;
    localparam int RECOV_CYC  = 2;
    localparam int L = SETUP_CYC + STROBE_CYC + HOLD_CYC + RECOV_CYC;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = '0;
    logic [1:0]  cmd_addr = '0;
    logic [1:0]  cmd_chan = '0;
    logic [2:0]  cmd_mode = '0;
    logic [15:0] cmd_data = '0;
    logic        done, err;
    logic [15:0] rsp_data;
    logic        cs_n, rd_n, wr_n, a1, a0, d_oe;
    logic [7:0]  d_out;
    logic [7:0]  d_in = '0;

    pit_bus_master #(
        .SETUP_CYC(SETUP_CYC), .STROBE_CYC(STROBE_CYC),
        .HOLD_CYC(HOLD_CYC), .RECOV_CYC(RECOV_CYC)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_chan(cmd_chan),
        .cmd_mode(cmd_mode), .cmd_data(cmd_data),
        .done(done), .err(err), .rsp_data(rsp_data),
        .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .a1(a1), .a0(a0),
        .d_out(d_out), .d_oe(d_oe), .d_in(d_in)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        bit       rd;
        bit [1:0] addr;
        bit [7:0] data;
        int       setup;
        int       strb;
        int       hold;
        int       gap;
        int       oe_cyc;
        bit       ok;
    } bus_rec_t;

    bus_rec_t mon_q[$];
    bus_rec_t cur;
    bit [7:0] rd_q[$];
    int       viol = 0;
    int       done_seen = 0;
    int       exp_done = 0;
    int       gap_cnt = 999;
    bit       rst_win = 1'b1;
    logic     p_cs_n = 1'b1, p_rd_n = 1'b1, p_wr_n = 1'b1;
    logic [15:0] exp_rsp = '0;

    // Bus monitor, protocol rule checker and 8253 read-data source
    always @(negedge clk) begin
        if (!rst_win) begin
            if (!rd_n && !wr_n) viol++;
            if (!rd_n && d_oe) viol++;
            if (cs_n && d_oe) viol++;
            if (((rd_n !== p_rd_n) || (wr_n !== p_wr_n)) && (cs_n || p_cs_n)) viol++;
            if ((cs_n !== p_cs_n) && !(rd_n && wr_n && p_rd_n && p_wr_n)) viol++;
            if (err && !done) viol++;
        end
        if (done) done_seen++;

        if (!cs_n) begin
            if (p_cs_n) begin
                cur = '{rd: 1'b0, addr: {a1, a0}, data: d_out, setup: 0, strb: 0,
                        hold: 0, gap: gap_cnt, oe_cyc: 0, ok: 1'b1};
            end
            if ({a1, a0} != cur.addr) cur.ok = 1'b0;
            if (d_oe) cur.oe_cyc++;
            if (!cur.rd && d_out != cur.data) cur.ok = 1'b0;
            if (!rd_n) begin
                cur.rd = 1'b1;
                cur.strb++;
            end else if (!wr_n) begin
                cur.strb++;
            end else if (cur.strb == 0) begin
                cur.setup++;
            end else begin
                cur.hold++;
            end
        end else begin
            if (!p_cs_n) begin
                mon_q.push_back(cur);
                gap_cnt = 1;
            end else if (gap_cnt < 999) begin
                gap_cnt++;
            end
        end

        // A fresh byte every strobe cycle; only the last one should be taken.
        if (!rd_n) begin
            d_in = 8'($urandom);
        end else begin
            if (!p_rd_n) rd_q.push_back(d_in);
            d_in = 8'($urandom);
        end

        p_cs_n = cs_n;
        p_rd_n = rd_n;
        p_wr_n = wr_n;
    end

    // Issue one command and compare everything it produced with the model.
    task automatic run_cmd(input logic [1:0] op, input logic [1:0] addr,
                           input logic [1:0] chan, input logic [2:0] mode,
                           input logic [15:0] data, input bit chained);
        bus_rec_t exp_q[$];
        bus_rec_t e;
        bit       is_err;
        int       exp_off;
        int       off;
        int       busy_bad;
        int       wait_n;

        is_err = (op == 2'b11) || (op != 2'b00 && chan == 2'b11);
        e = '{rd: 1'b0, addr: 2'b00, data: 8'h00, setup: SETUP_CYC, strb: STROBE_CYC,
              hold: HOLD_CYC, gap: RECOV_CYC, oe_cyc: 0, ok: 1'b1};
        if (!is_err) begin
            if (op == 2'b00) begin
                e.addr = addr; e.data = data[7:0]; exp_q.push_back(e);
            end else if (op == 2'b01) begin
                e.addr = 2'd3; e.data = {chan, 2'b11, mode, 1'b0}; exp_q.push_back(e);
                e.addr = chan; e.data = data[7:0];                 exp_q.push_back(e);
                e.addr = chan; e.data = data[15:8];                exp_q.push_back(e);
            end else begin
                e.addr = 2'd3; e.data = {chan, 6'b000000};         exp_q.push_back(e);
                e.rd = 1'b1; e.addr = chan; e.data = 8'h00;        exp_q.push_back(e);
                                                                   exp_q.push_back(e);
            end
        end
        exp_off = is_err ? 1 : exp_q.size() * L;

        mon_q.delete();
        rd_q.delete();
        cmd_op = op; cmd_addr = addr; cmd_chan = chan; cmd_mode = mode; cmd_data = data;
        cmd_valid = 1'b1;
        wait_n = 0;
        while (!cmd_ready && wait_n < 50) begin
            @(negedge clk); #1;
            wait_n++;
        end
        chk("accept_ready", cmd_ready, 1'b1);
        @(posedge clk);
        @(negedge clk); #1;
        // Scramble the inputs: the command must already be captured.
        cmd_valid = 1'b0;
        cmd_op = 2'($urandom); cmd_addr = 2'($urandom); cmd_chan = 2'($urandom);
        cmd_mode = 3'($urandom); cmd_data = 16'($urandom);
        off = 1;
        busy_bad = 0;
        while (!done && off < 200) begin
            if (cmd_ready) busy_bad++;
            @(negedge clk); #1;
            off++;
        end
        exp_done++;
        chk("done_cycle", off, exp_off);
        chk("err", err, is_err);
        chk("ready_at_done", cmd_ready, 1'b1);
        if (!is_err) chk("busy_ready_low", busy_bad, 0);
        if (op == 2'b10 && !is_err) begin
            chk("read_count", rd_q.size(), 2);
            if (rd_q.size() >= 2) exp_rsp = {rd_q[1], rd_q[0]};
        end
        chk("rsp_data", rsp_data, exp_rsp);
        chk("bus_cycles", mon_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
            chk("bus_rd", mon_q[i].rd, exp_q[i].rd);
            chk("bus_addr", mon_q[i].addr, exp_q[i].addr);
            if (!exp_q[i].rd) chk("bus_wdata", mon_q[i].data, exp_q[i].data);
            chk("t_setup", mon_q[i].setup, exp_q[i].setup);
            chk("t_strobe", mon_q[i].strb, exp_q[i].strb);
            chk("t_hold", mon_q[i].hold, exp_q[i].hold);
            chk("d_oe_cycles", mon_q[i].oe_cyc,
                exp_q[i].rd ? 0 : SETUP_CYC + STROBE_CYC + HOLD_CYC);
            chk("bus_stable", mon_q[i].ok, 1'b1);
            if (i > 0 || chained) chk("t_recov", mon_q[i].gap, exp_q[i].gap);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  ds;
        bit  prev_bus;
        logic [1:0] op, ch;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk); #1;
        rst_win = 1'b0;
        chk("rst_cs_n", cs_n, 1'b1);
        chk("rst_rd_n", rd_n, 1'b1);
        chk("rst_wr_n", wr_n, 1'b1);
        chk("rst_addr", {a1, a0}, 2'b00);
        chk("rst_d_out", d_out, 8'h00);
        chk("rst_d_oe", d_oe, 1'b0);
        chk("rst_ready", cmd_ready, 1'b1);
        chk("rst_done", {done, err}, 2'b00);
        chk("rst_rsp", rsp_data, 16'h0000);

        run_cmd(2'b00, 2'd3, 2'd0, 3'd0, 16'h0036, 1'b0);
        run_cmd(2'b01, 2'd0, 2'd1, 3'd2, 16'h0012, 1'b0);
        run_cmd(2'b10, 2'd0, 2'd2, 3'd0, 16'h0000, 1'b0);
        run_cmd(2'b01, 2'd0, 2'd3, 3'd3, 16'h1234, 1'b0);
        run_cmd(2'b11, 2'd1, 2'd0, 3'd0, 16'h00FF, 1'b0);
        run_cmd(2'b00, 2'd1, 2'd0, 3'd0, 16'h005A, 1'b0);
        run_cmd(2'b00, 2'd2, 2'd0, 3'd0, 16'h00A5, 1'b1);

        // Reset in the middle of the second byte's strobe of a program command.
        cmd_op = 2'b01; cmd_chan = 2'd0; cmd_mode = 3'd3; cmd_data = 16'hBEEF;
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk); #1;
        cmd_valid = 1'b0;
        repeat (L + SETUP_CYC) begin
            @(negedge clk); #1;
        end
        chk("rst_mid_strobe", {cs_n, wr_n}, 2'b00);
        ds = done_seen;
        rst_win = 1'b1;
        reset = 1'b1;
        @(negedge clk); #1;
        chk("mid_rst_cs_wr", {cs_n, wr_n, rd_n}, 3'b111);
        chk("mid_rst_d_oe", d_oe, 1'b0);
        chk("mid_rst_ready", cmd_ready, 1'b1);
        chk("mid_rst_done", {done, err}, 2'b00);
        chk("mid_rst_rsp", rsp_data, 16'h0000);
        reset = 1'b0;
        exp_rsp = '0;
        repeat (4) begin
            @(negedge clk); #1;
        end
        chk("mid_rst_no_done", done_seen, ds);
        rst_win = 1'b0;
        run_cmd(2'b00, 2'd0, 2'd0, 3'd0, 16'h00C3, 1'b0);

        prev_bus = 1'b1;
        for (int n = 0; n < 40; n++) begin
            int sel;
            int idle;
            sel = $urandom_range(0, 9);
            op = (sel < 3) ? 2'b00 : (sel < 6) ? 2'b01 : (sel < 9) ? 2'b10 : 2'b11;
            ch = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            idle = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
            repeat (idle) begin
                @(negedge clk); #1;
            end
            run_cmd(op, 2'($urandom), ch, 3'($urandom), 16'($urandom),
                    (idle == 0) && prev_bus);
            prev_bus = !((op == 2'b11) || (op != 2'b00 && ch == 2'b11));
        end

        repeat (3) begin
            @(negedge clk); #1;
        end
        chk("protocol_rules", viol, 0);
        chk("done_count", done_seen, exp_done);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
